// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and BRAM port constants for the two-requester BRAM port arbiter.
package bram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN0   = 2'd1,
        ST_OWN1   = 2'd2,
        ST_SWITCH = 2'd3
    } arb_state_t;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WE_W   = 4;

    localparam logic [WE_W-1:0] WE_FULL = 4'b1111;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way round-robin decision: on a tie, the requester that did not own last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic winner
);

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_owner;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin owner of the single BRAM port shared by the rotation sequencer (0)
// and the host loader (1), with burst locking and a bounded hold time.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              en0,
    input  logic              en1,
    input  logic [WE_W-1:0]   we0,
    input  logic [WE_W-1:0]   we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] addr_bram,
    output logic [DATA_W-1:0] dout_bram,
    input  logic [DATA_W-1:0] din_bram,
    output logic              en_bram,
    output logic [WE_W-1:0]   we_bram
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_next;
    logic             r_last_owner;
    logic             w_last_owner_next;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_rvld0_p1;
    logic             r_rvld1_p1;
    logic             w_winner;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= HOLD_MAX) begin
            return HOLD_MAX;
        end
        return v + 1'b1;
    endfunction

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_owner (r_last_owner),
        .winner     (w_winner)
    );

    always_comb begin
        w_state_next      = r_state;
        w_last_owner_next = r_last_owner;
        w_hold_cnt_next   = '0;
        case (r_state)
            ST_IDLE, ST_SWITCH: begin
                if (req0 || req1) begin
                    w_state_next = w_winner ? ST_OWN1 : ST_OWN0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!req0 || (req1 && !lock0 && (r_hold_cnt == HOLD_MAX))) begin
                    w_state_next      = ST_SWITCH;
                    w_last_owner_next = 1'b0;
                end else if (req1) begin
                    w_hold_cnt_next = sat_inc(r_hold_cnt);
                end
            end
            ST_OWN1: begin
                if (!req1 || (req0 && !lock1 && (r_hold_cnt == HOLD_MAX))) begin
                    w_state_next      = ST_SWITCH;
                    w_last_owner_next = 1'b1;
                end else if (req0) begin
                    w_hold_cnt_next = sat_inc(r_hold_cnt);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Stage p0 -> p1: grant/state register and read-valid return alongside BRAM latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_last_owner <= 1'b1;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rvld0_p1   <= 1'b0;
            r_rvld1_p1   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hold_cnt   <= w_hold_cnt_next;
            r_last_owner <= w_last_owner_next;
            r_gnt0       <= (w_state_next == ST_OWN0);
            r_gnt1       <= (w_state_next == ST_OWN1);
            r_rvld0_p1   <= r_gnt0 && en0 && (we0 == '0);
            r_rvld1_p1   <= r_gnt1 && en1 && (we1 == '0);
        end
    end

    always_comb begin
        en_bram   = 1'b0;
        we_bram   = '0;
        addr_bram = '0;
        dout_bram = '0;
        if (r_gnt0) begin
            en_bram   = en0;
            we_bram   = we0 & (en0 ? WE_FULL : '0);
            addr_bram = addr0;
            dout_bram = wdata0;
        end else if (r_gnt1) begin
            en_bram   = en1;
            we_bram   = we1 & (en1 ? WE_FULL : '0);
            addr_bram = addr1;
            dout_bram = wdata1;
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign rvalid0 = r_rvld0_p1;
    assign rvalid1 = r_rvld1_p1;
    assign rdata   = din_bram;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 1-cycle-latency BRAM model, MAX_HOLD=4.
module tb_bram_port_arbiter;
    import bram_port_arbiter_pkg::*;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned CNT_W    = 3;
    localparam logic [31:0] WDATA1   = 32'hA5A5_0033;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, lock0, lock1;
    logic              gnt0, gnt1;
    logic              en0, en1;
    logic [WE_W-1:0]   we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [DATA_W-1:0] rdata;
    logic              rvalid0, rvalid1;
    logic [ADDR_W-1:0] addr_bram;
    logic [DATA_W-1:0] dout_bram;
    logic [DATA_W-1:0] din_bram;
    logic              en_bram;
    logic [WE_W-1:0]   we_bram;

    logic [31:0] mem [0:15];
    logic        preload;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .lock0     (lock0),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .en0       (en0),
        .en1       (en1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .rdata     (rdata),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .addr_bram (addr_bram),
        .dout_bram (dout_bram),
        .din_bram  (din_bram),
        .en_bram   (en_bram),
        .we_bram   (we_bram)
    );

    // Read-first BRAM, one cycle read latency, word index from byte address bits [5:2]
    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'h0;
        end else if (en_bram) begin
            for (int b = 0; b < 4; b++) begin
                if (we_bram[b]) mem[addr_bram[5:2]][b*8 +: 8] <= dout_bram[b*8 +: 8];
            end
            din_bram <= mem[addr_bram[5:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        check({tag, " gnt0"}, gnt0, 0);
        check({tag, " gnt1"}, gnt1, 0);
        check({tag, " rvalid0"}, rvalid0, 0);
        check({tag, " rvalid1"}, rvalid1, 0);
        check({tag, " en_bram"}, en_bram, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset  = 1'b0; preload = 1'b1;
        req0   = 0; req1 = 0; lock0 = 0; lock1 = 0;
        en0    = 0; en1 = 0; we0 = '0; we1 = '0;
        addr0  = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step();
        preload = 1'b0;
        do_reset("rst");

        // 1: single read by requester 0
        req0 = 1; en0 = 1; addr0 = 32'h10; we0 = '0;
        #1;
        check("t1 gnt0 not yet", gnt0, 0);
        step();
        check("t1 gnt0", gnt0, 1);
        check("t1 gnt1", gnt1, 0);
        check("t1 en_bram", en_bram, 1);
        check("t1 addr_bram", addr_bram, 32'h10);
        check("t1 we_bram", we_bram, 0);
        step();
        check("t1 rvalid0", rvalid0, 1);
        check("t1 rdata", rdata, 32'hDEADBEEF);
        check("t1 rvalid1", rvalid1, 0);
        req0 = 0; en0 = 0;
        step();
        check("t1 release gnt0", gnt0, 0);
        step();

        // 2: tie alternation
        do_reset("t2 rst");
        req0 = 1; req1 = 1;
        step();
        check("t2 first gnt0", gnt0, 1);
        check("t2 first gnt1", gnt1, 0);
        req0 = 0;
        step();
        check("t2 dead gnt0", gnt0, 0);
        check("t2 dead gnt1", gnt1, 0);
        step();
        check("t2 then gnt1", gnt1, 1);
        check("t2 then gnt0", gnt0, 0);
        req0 = 1;
        step();
        check("t2 gnt1 held", gnt1, 1);
        req1 = 0;
        step();
        check("t2 switch gnt0", gnt0, 0);
        check("t2 switch gnt1", gnt1, 0);
        req1 = 1;
        step();
        check("t2 alt gnt0", gnt0, 1);
        check("t2 alt gnt1", gnt1, 0);
        req0 = 0; req1 = 0;
        step();
        step();

        // 3: preemption of unlocked owner 1 after hold limit
        req1 = 1;
        step();
        check("t3 gnt1", gnt1, 1);
        req0 = 1; en1 = 1; we1 = WE_FULL; addr1 = 32'h20; wdata1 = WDATA1;
        #1;
        check("t3 we_bram first", we_bram, 4'hF);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3 hold gnt1", gnt1, 1);
            check("t3 hold we_bram", we_bram, 4'hF);
        end
        step();
        check("t3 preempt gnt1", gnt1, 0);
        check("t3 preempt gnt0", gnt0, 0);
        check("t3 masked we_bram", we_bram, 0);
        check("t3 masked en_bram", en_bram, 0);
        step();
        check("t3 handover gnt0", gnt0, 1);
        check("t3 handover gnt1", gnt1, 0);
        check("t3 handover we_bram", we_bram, 0);
        check("t3 mem written", mem[8], WDATA1);
        req1 = 0; en1 = 0; we1 = '0; req0 = 0;
        step();
        step();

        // 4: lock blocks preemption
        req0 = 1; req1 = 1; lock1 = 1;
        step();
        check("t4 gnt1", gnt1, 1);
        check("t4 gnt0", gnt0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t4 locked gnt1", gnt1, 1);
        end
        lock1 = 0;
        step();
        check("t4 unlock gnt1", gnt1, 0);
        check("t4 unlock gnt0", gnt0, 0);
        step();
        check("t4 gnt0", gnt0, 1);
        req1 = 0;

        // 5: read in last owned cycle returns during SWITCH
        en0 = 1; we0 = '0; addr0 = 32'h10; req0 = 0;
        step();
        check("t5 switch gnt0", gnt0, 0);
        check("t5 rvalid0", rvalid0, 1);
        check("t5 rvalid1", rvalid1, 0);
        check("t5 rdata", rdata, 32'hDEADBEEF);
        en0 = 0;
        step();
        check("t5 rvalid0 clears", rvalid0, 0);

        // 6: reset during OWN1 with a read in flight
        req1 = 1;
        step();
        check("t6 gnt1", gnt1, 1);
        en1 = 1; we1 = '0; addr1 = 32'h20;
        step();
        check("t6 rvalid1", rvalid1, 1);
        check("t6 rdata", rdata, WDATA1);
        reset = 0;
        step();
        check("t6 rst gnt1", gnt1, 0);
        check("t6 rst rvalid1", rvalid1, 0);
        check("t6 rst en_bram", en_bram, 0);
        check("t6 rst we_bram", we_bram, 0);
        reset = 1;
        step();
        check("t6 regrant gnt1", gnt1, 1);
        check("t6 regrant gnt0", gnt0, 0);
        req1 = 0; en1 = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
